decoder_stage_controller: RTL and testbench
===========================================

# decoder_stage_controller

Sequencing controller that drives a single-FPGA decoding graph through one union-find decode per syndrome. It accepts a syndrome frame over a valid/ready handshake and loads it into the graph's `measurements` input. It then alternates grow and merge stages, using the graph's registered `busy` and `odd_clusters` summaries to decide when to stop, and presents a result handshake once no odd cluster remains.

## Interface
Parameters:
- `CODE_DISTANCE_X`, 3: graph rows.
- `CODE_DISTANCE_Z`, 2: graph columns.
- `MAX_ITERATIONS`, 16: grow/merge round limit; used only under `DECODER_TIMEOUT_EN`.
- `MERGE_SETTLE_CYCLES`, 3: consecutive `busy`=0 cycles required to leave MERGE (range 1..15).
- `STAGE_WIDTH`, 3: stage code width.
- Derived: `PU_COUNT` = X·Z·max(X,Z); `ITER_WIDTH` = $clog2(MAX_ITERATIONS+1).

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `syndrome_valid`  in  1  syndrome frame available.
- `syndrome_ready`  out  1  controller can accept a frame.
- `syndrome_data`  in  PU_COUNT  frame, one bit per PU.
- `measurements`  out  PU_COUNT  registered frame to the graph.
- `stage`  out  STAGE_WIDTH  registered stage code to the graph.
- `global_stage`  out  1  one-cycle strobe on the first cycle of every new `stage` value.
- `busy`  in  1  registered OR of PU busy from the graph.
- `odd_clusters`  in  1  registered OR of PU odd flags from the graph.
- `result_valid`  out  1  decode complete; roots in the graph are stable.
- `result_ready`  in  1  consumer accepts the result.
- `iteration_count`  out  ITER_WIDTH  grow rounds executed in the current or last decode.
- `timeout`  out  1  decode ended at the iteration limit.

## Operation
- Stage codes: IDLE=0, MEASUREMENT_LOADING=1, GROW=2, MERGE=3, RESULT_VALID=5. Codes 4, 6 and 7 are never driven.
- IDLE:
  - `syndrome_ready`=1.
  - On `syndrome_valid & syndrome_ready`: capture `syndrome_data` into `measurements`, clear `iteration_count` and `timeout`, go to MEASUREMENT_LOADING.
- MEASUREMENT_LOADING: lasts exactly 1 cycle, then GROW.
- GROW:
  - Lasts exactly 1 cycle.
  - `iteration_count` increments by 1, saturating at all-ones.
  - Then MERGE.
- MERGE:
  - A settle counter clears on entry.
  - The counter increments on each cycle with `busy`=0 and clears on any cycle with `busy`=1.
  - When the counter equals `MERGE_SETTLE_CYCLES`, sample `odd_clusters`:
    - `odd_clusters`=1 → GROW.
    - `odd_clusters`=0 → RESULT_VALID.
- RESULT_VALID:
  - `result_valid`=1, held until `result_ready`=1.
  - The accept cycle returns to IDLE.
  - `measurements` keeps the last frame until the next capture.
- `global_stage` is 1 exactly in cycles where `stage` differs from its previous-cycle value.
- `syndrome_valid` outside IDLE is ignored; a frame is never captured mid-decode.

## Timing
- Reset values: `stage`=IDLE(0), `global_stage`=0, `measurements`=0, `syndrome_ready`=1, `result_valid`=0, `iteration_count`=0, `timeout`=0. State returns to IDLE asynchronously on `reset`, including mid-decode; the settle counter clears.
- Handshake to `stage`=1: one cycle.
- Decode with zero odd clusters: LOADING (1) + GROW (1) + MERGE (≥`MERGE_SETTLE_CYCLES`). `result_valid` rises at handshake + 3 + `MERGE_SETTLE_CYCLES` cycles at the earliest.
- Each extra round adds 1 + merge dwell cycles.
- `result_valid & result_ready` in the same cycle: `syndrome_ready`=1 on the next cycle; earliest new capture is that cycle.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- `DECODER_TIMEOUT_EN` defined:
  - In MERGE, when the exit condition is met with `odd_clusters`=1 and `iteration_count` = `MAX_ITERATIONS`, go to RESULT_VALID with `timeout`=1.
  - `timeout` holds until the next capture or reset.
- `DECODER_TIMEOUT_EN` undefined:
  - Grow/merge loops until `odd_clusters`=0.
  - `timeout` is tied to 0.
  - The iteration limit logic is not synthesised.

## Test plan
- Reset mid-MERGE: assert `reset` while `stage`=3 → same-cycle async return: `stage`=0, `syndrome_ready`=1, `result_valid`=0, `iteration_count`=0.
- Empty syndrome: frame 0, `busy`=0, `odd_clusters`=0, `MERGE_SETTLE_CYCLES`=3 → `stage` sequence 1,2,3,3,3,5; `result_valid` on cycle 6 after handshake; `iteration_count`=1; `global_stage` pulses 4 times.
- Two rounds with busy bursts: `odd_clusters`=1 after the first merge, then 0; `busy`=1 for 2 cycles mid-merge → settle restarts; exit needs 3 consecutive idle cycles; `iteration_count`=2.
- Backpressure: hold `result_ready`=0 for 10 cycles → `result_valid` and `stage`=5 stable, `global_stage`=0. Drive `syndrome_valid`=1 throughout → no capture until IDLE.
- Back-to-back frames: `result_ready`=1 and `syndrome_valid`=1 continuously → new capture on the cycle after accept; `measurements` updates to frame B.
- `DECODER_TIMEOUT_EN`, `MAX_ITERATIONS`=4, `odd_clusters` stuck at 1 → exit after 4 grows with `timeout`=1 and `iteration_count`=4. Without the macro: still in GROW/MERGE after 100 rounds, `timeout`=0.

Source files
------------

// File: rtl/decoder_stage_if.sv
// Handshake and graph-control bundle between decoder_stage_controller (master)
// and the syndrome source / decoding graph / result consumer (slave).
interface decoder_stage_if #(
  parameter int PU_COUNT    = 18,
  parameter int STAGE_WIDTH = 3,
  parameter int ITER_WIDTH  = 5
);
  logic                   syndrome_valid;
  logic                   syndrome_ready;
  logic [PU_COUNT-1:0]    syndrome_data;
  logic [PU_COUNT-1:0]    measurements;
  logic [STAGE_WIDTH-1:0] stage;
  logic                   global_stage;
  logic                   busy;
  logic                   odd_clusters;
  logic                   result_valid;
  logic                   result_ready;
  logic [ITER_WIDTH-1:0]  iteration_count;
  logic                   timeout;

  modport master (
    input  syndrome_valid, syndrome_data, busy, odd_clusters, result_ready,
    output syndrome_ready, measurements, stage, global_stage, result_valid,
           iteration_count, timeout
  );

  modport slave (
    output syndrome_valid, syndrome_data, busy, odd_clusters, result_ready,
    input  syndrome_ready, measurements, stage, global_stage, result_valid,
           iteration_count, timeout
  );
endinterface

// File: rtl/decoder_stage_controller.sv
// Sequences one union-find decode per syndrome: load, then grow/merge rounds until no odd cluster.
// Optional iteration limit with timeout flag is enabled by defining DECODER_TIMEOUT_EN.
module decoder_stage_controller #(
  parameter int CODE_DISTANCE_X     = 3,
  parameter int CODE_DISTANCE_Z     = 2,
  parameter int MAX_ITERATIONS      = 16,
  parameter int MERGE_SETTLE_CYCLES = 3,
  parameter int STAGE_WIDTH         = 3
) (
  input  logic             clk,
  input  logic             reset,
  decoder_stage_if.master  bus
);

  localparam int PU_COUNT = CODE_DISTANCE_X * CODE_DISTANCE_Z *
                            ((CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z);
  localparam int ITER_WIDTH = $clog2(MAX_ITERATIONS + 1);
  localparam logic [3:0] SETTLE_LAST = 4'(MERGE_SETTLE_CYCLES - 1);
  localparam logic [ITER_WIDTH-1:0] ITER_SAT = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_GROW   = 3'd2,
    S_MERGE  = 3'd3,
    S_RESULT = 3'd5
  } state_t;

  state_t                state, state_next;
  logic [3:0]            settle_cnt;
  logic [PU_COUNT-1:0]   meas_q;
  logic [ITER_WIDTH-1:0] iter_q;
  logic                  global_stage_q;
  logic                  syndrome_ready_q;
  logic                  result_valid_q;
  logic                  capture;
  logic                  merge_exit;
  logic                  timeout_hit;

  // Exit fires on the idle cycle that would bring the settle count up to MERGE_SETTLE_CYCLES.
  assign merge_exit = (state == S_MERGE) && !bus.busy && (settle_cnt == SETTLE_LAST);

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.syndrome_valid && syndrome_ready_q) begin
          capture    = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD:  state_next = S_GROW;
      S_GROW:  state_next = S_MERGE;
      S_MERGE: begin
        if (merge_exit)
          state_next = (bus.odd_clusters && !timeout_hit) ? S_GROW : S_RESULT;
      end
      S_RESULT: begin
        if (bus.result_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Registered outputs are computed from the next state so they line up with stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt       <= '0;
      meas_q           <= '0;
      iter_q           <= '0;
      global_stage_q   <= 1'b0;
      syndrome_ready_q <= 1'b1;
      result_valid_q   <= 1'b0;
    end else begin
      global_stage_q   <= (state_next != state);
      syndrome_ready_q <= (state_next == S_IDLE);
      result_valid_q   <= (state_next == S_RESULT);
      if (state != S_MERGE || bus.busy) settle_cnt <= '0;
      else                              settle_cnt <= settle_cnt + 4'd1;
      if (capture) meas_q <= bus.syndrome_data;
      if (capture)                                iter_q <= '0;
      else if (state == S_GROW && iter_q != ITER_SAT) iter_q <= iter_q + 1'b1;
    end
  end

`ifdef DECODER_TIMEOUT_EN
  logic timeout_q;

  assign timeout_hit = merge_exit && bus.odd_clusters &&
                       (iter_q == ITER_WIDTH'(MAX_ITERATIONS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            timeout_q <= 1'b0;
    else if (capture)     timeout_q <= 1'b0;
    else if (timeout_hit) timeout_q <= 1'b1;
  end

  assign bus.timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.stage           = STAGE_WIDTH'(state);
  assign bus.global_stage    = global_stage_q;
  assign bus.syndrome_ready  = syndrome_ready_q;
  assign bus.result_valid    = result_valid_q;
  assign bus.measurements    = meas_q;
  assign bus.iteration_count = iter_q;

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Self-checking bench for decoder_stage_controller: scripted graph model plus result scoreboard.
module tb_decoder_stage_controller;

  localparam int DX  = 3;
  localparam int DZ  = 2;
  localparam int MSC = 3;
  localparam int SW  = 3;
`ifdef DECODER_TIMEOUT_EN
  localparam int MAX_IT = 4;
`else
  localparam int MAX_IT = 16;
`endif
  localparam int PU = DX * DZ * ((DX > DZ) ? DX : DZ);
  localparam int IW = $clog2(MAX_IT + 1);

  typedef struct {
    logic [PU-1:0] frame;
    int            iters;
    logic          tmo;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_bad = 0;
  int   gs_cnt;
  int   hist [32];
  exp_t sb_q [$];

  always #5 clk = ~clk;

  decoder_stage_if #(.PU_COUNT(PU), .STAGE_WIDTH(SW), .ITER_WIDTH(IW)) bus ();

  decoder_stage_controller #(
    .CODE_DISTANCE_X(DX), .CODE_DISTANCE_Z(DZ), .MAX_ITERATIONS(MAX_IT),
    .MERGE_SETTLE_CYCLES(MSC), .STAGE_WIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake one frame; leaves syndrome_valid low and the bench on the stage-1 cycle.
  task automatic send(input logic [PU-1:0] frame, input int iters, input logic tmo, input bit push);
    int w;
    w = 0;
    while (!bus.syndrome_ready && w < 50) begin tick(); w++; end
    check_eq("ready_before_send", bus.syndrome_ready, 1);
    if (push) sb_q.push_back('{frame, iters, tmo});
    bus.syndrome_valid = 1'b1;
    bus.syndrome_data  = frame;
    tick();
    bus.syndrome_valid = 1'b0;
    check_eq("stage_after_hs", bus.stage, 1);
    check_eq("meas_captured", bus.measurements, frame);
    check_eq("iter_cleared", bus.iteration_count, 0);
    check_eq("tmo_cleared", bus.timeout, 0);
  endtask

  // Graph model: odd clusters remain until 'rounds' grows done; optional busy burst in merge 1.
  task automatic run_to_result(input int rounds, input bit burst, output int lat, output int mlen1);
    int grows, mcyc;
    grows = 0; mcyc = 0; lat = 1; mlen1 = 0; gs_cnt = 0;
    while (lat < 600) begin
      if (lat < 32) hist[lat] = int'(bus.stage);
      gs_cnt += int'(bus.global_stage);
      if (bus.result_valid) break;
      if (bus.stage == 3'd2) begin grows++; mcyc = 0; end
      if (bus.stage == 3'd3) begin mcyc++; if (grows == 1) mlen1++; end
      bus.odd_clusters = (grows < rounds);
      bus.busy = burst && (grows == 1) && (mcyc == 2 || mcyc == 3);
      tick();
      lat++;
    end
    bus.busy = 1'b0;
    bus.odd_clusters = 1'b0;
    check_eq("rv_seen", bus.result_valid, 1);
  endtask

  task automatic check_result();
    exp_t e;
    check_eq("sb_nonempty", sb_q.size() > 0, 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("res_meas", bus.measurements, e.frame);
      check_eq("res_iters", bus.iteration_count, e.iters);
      check_eq("res_tmo", bus.timeout, e.tmo);
    end
  endtask

  // Hold off result_ready for bp cycles (with a competing frame offered), then accept.
  task automatic accept(input int bp);
    bit stable;
    stable = 1'b1;
    bus.syndrome_valid = (bp > 0);
    bus.syndrome_data  = '1;
    for (int i = 0; i < bp; i++) begin
      tick();
      if (!bus.result_valid || bus.stage != 3'd5 || bus.global_stage || bus.syndrome_ready)
        stable = 1'b0;
    end
    if (bp > 0) check_eq("bp_stable", stable, 1);
    bus.syndrome_valid = 1'b0;
    check_result();
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check_eq("idle_stage", bus.stage, 0);
    check_eq("idle_ready", bus.syndrome_ready, 1);
    check_eq("idle_rv", bus.result_valid, 0);
    check_eq("idle_gs", bus.global_stage, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ml, w;
    logic [PU-1:0] fa, fb;
    bit ok;
    reset = 1'b0;
    bus.syndrome_valid = 1'b0;
    bus.syndrome_data  = '0;
    bus.busy           = 1'b0;
    bus.odd_clusters   = 1'b0;
    bus.result_ready   = 1'b0;
    #2 reset = 1'b1;
    tick();
    check_eq("rst_stage", bus.stage, 0);
    check_eq("rst_gs", bus.global_stage, 0);
    check_eq("rst_meas", bus.measurements, 0);
    check_eq("rst_ready", bus.syndrome_ready, 1);
    check_eq("rst_rv", bus.result_valid, 0);
    check_eq("rst_iter", bus.iteration_count, 0);
    check_eq("rst_tmo", bus.timeout, 0);
    reset = 1'b0;
    tick();

    // Empty syndrome
    send('0, 1, 1'b0, 1'b1);
    run_to_result(1, 1'b0, lat, ml);
    check_eq("empty_lat", lat, 3 + MSC);
    check_eq("empty_s1", hist[1], 1);
    check_eq("empty_s2", hist[2], 2);
    check_eq("empty_s3", hist[3], 3);
    check_eq("empty_s4", hist[4], 3);
    check_eq("empty_s5", hist[5], 3);
    check_eq("empty_s6", hist[6], 5);
    check_eq("empty_gs_pulses", gs_cnt, 4);
    accept(0);

    // Two rounds with a busy burst in the first merge
    fa = PU'(18'h2a5c3);
    send(fa, 2, 1'b0, 1'b1);
    run_to_result(2, 1'b1, lat, ml);
    check_eq("burst_merge_len", ml, MSC + 3);
    check_eq("burst_lat", lat, 3 + MSC + (1 + MSC) + 3);
    accept(0);

    // Backpressure with syndrome_valid held high
    fa = PU'(18'h13579);
    send(fa, 1, 1'b0, 1'b1);
    run_to_result(1, 1'b0, lat, ml);
    check_eq("bp_lat", lat, 3 + MSC);
    accept(10);

    // Back-to-back frames with result_ready and syndrome_valid held high
    fa = PU'(18'h0f0f0);
    fb = PU'(18'h30303);
    send(fa, 1, 1'b0, 1'b1);
    bus.result_ready   = 1'b1;
    bus.syndrome_valid = 1'b1;
    bus.syndrome_data  = fb;
    run_to_result(1, 1'b0, lat, ml);
    check_result();
    tick();
    check_eq("b2b_idle_stage", bus.stage, 0);
    check_eq("b2b_idle_ready", bus.syndrome_ready, 1);
    sb_q.push_back('{fb, 1, 1'b0});
    tick();
    bus.syndrome_valid = 1'b0;
    check_eq("b2b_stage_load", bus.stage, 1);
    check_eq("b2b_meas_b", bus.measurements, fb);
    run_to_result(1, 1'b0, lat, ml);
    check_result();
    tick();
    bus.result_ready = 1'b0;
    check_eq("b2b_back_idle", bus.stage, 0);

    // Stuck odd clusters
`ifdef DECODER_TIMEOUT_EN
    fa = PU'(18'h00fff);
    send(fa, MAX_IT, 1'b1, 1'b1);
    run_to_result(1000, 1'b0, lat, ml);
    check_eq("tmo_lat", lat, 3 + MSC + (MAX_IT - 1) * (1 + MSC));
    accept(0);
    check_eq("tmo_hold", bus.timeout, 1);
    send(PU'(18'h00001), 0, 1'b0, 1'b0);
    bus.odd_clusters = 1'b1;
`else
    send(PU'(18'h00001), 0, 1'b0, 1'b0);
    bus.odd_clusters = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 100 * (1 + MSC) + 10; i++) begin
      tick();
      if (bus.result_valid || !(bus.stage == 3'd2 || bus.stage == 3'd3) || bus.timeout) ok = 1'b0;
    end
    check_eq("no_limit_loop", ok, 1);
    check_eq("iter_saturated", bus.iteration_count, (1 << IW) - 1);
`endif

    // Asynchronous reset while in MERGE
    w = 0;
    while (bus.stage != 3'd3 && w < 10) begin tick(); w++; end
    check_eq("reach_merge", bus.stage, 3);
    reset = 1'b1;
    #1;
    check_eq("arst_stage", bus.stage, 0);
    check_eq("arst_ready", bus.syndrome_ready, 1);
    check_eq("arst_rv", bus.result_valid, 0);
    check_eq("arst_iter", bus.iteration_count, 0);
    bus.odd_clusters = 1'b0;
    sb_q.delete();
    tick();
    reset = 1'b0;
    tick();

    // Recovery decode with three rounds
    fa = PU'($urandom_range(0, (1 << PU) - 1));
    send(fa, 3, 1'b0, 1'b1);
    run_to_result(3, 1'b0, lat, ml);
    check_eq("three_lat", lat, 3 + MSC + 2 * (1 + MSC));
    accept(0);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
